// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and line geometry for the memory arbiter
package mem_arb_pkg;
  localparam int LINE_W = 128;
  localparam int OFFSET_BITS = 4;
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the arbiter (slave = arbiter view, master = environment view)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = mem_arb_pkg::LINE_W
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, resp_err, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, resp_err, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick between I and D with last-owner register
module rr_arbiter_2 import mem_arb_pkg::*; (
  input  logic   clk,
  input  logic   reset,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   upd,
  input  owner_e upd_own,
  output owner_e pick
);
  owner_e last_q, last_d;
  always_comb last_d = upd ? upd_own : last_q;
  assign pick = (req_i && (!req_d || last_q == OWN_D)) ? OWN_I : OWN_D;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= OWN_D;
    else last_q <= last_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I/D line refills and D writebacks onto one memory port with a watchdog
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d, err_q, err_d, upd, is_i, expired, in_busy, in_resp;
  logic [LINE_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [WD_W-1:0] wd_q, wd_d;
  owner_e pick, upd_own;
  rr_arbiter_2 u_rr (
    .clk(clk), .reset(reset), .req_i(bus.i_req), .req_d(bus.d_req),
    .upd(upd), .upd_own(upd_own), .pick(pick)
  );
  assign is_i = state_q == BUSY_I || state_q == RESP_I;
  assign expired = wd_q == WD_W'(TIMEOUT - 1);
  assign in_busy = state_q == BUSY_I || state_q == BUSY_D;
  assign in_resp = state_q == RESP_I || state_q == RESP_D;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d = err_q;
    wd_d = wd_q;
    upd = 1'b0;
    upd_own = is_i ? OWN_I : OWN_D;
    unique case (state_q)
      IDLE: if (bus.i_req || bus.d_req) begin
        err_d = 1'b0;
        wd_d = '0;
        state_d = pick == OWN_I ? BUSY_I : BUSY_D;
        addr_d = (pick == OWN_I ? bus.i_addr : bus.d_addr) & LINE_MASK;
        we_d = pick == OWN_D && bus.d_we;
        wdata_d = pick == OWN_I ? '0 : bus.d_wdata;
      end
      BUSY_I, BUSY_D: if (bus.mem_ready || expired) begin
        // mem_ready beats a same-cycle watchdog expiry; a timeout returns a zero line
        state_d = is_i ? RESP_I : RESP_D;
        err_d = !bus.mem_ready;
        if (is_i) i_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
        else if (!bus.mem_ready || !we_q) d_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
      end else wd_d = wd_q + 1'b1;
      RESP_I, RESP_D: begin
        state_d = IDLE;
        upd = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q <= 1'b0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q <= err_d;
      wd_q <= wd_d;
    end
  assign bus.busy = state_q != IDLE;
  assign bus.mem_req = in_busy;
  assign bus.mem_we = in_busy && we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ready = state_q == RESP_I;
  assign bus.d_ready = state_q == RESP_D;
  assign bus.resp_err = in_resp && err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();
  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xact(input string tag, input bit is_i, input logic [31:0] exp_addr, input bit exp_we,
                      input logic [127:0] exp_wd, input int n, input logic [127:0] mrd, input logic [127:0] exp_rd);
    tick;
    chk({tag, ".mem_req"}, bus.mem_req, 1);
    chk({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
    chk({tag, ".mem_we"}, bus.mem_we, exp_we);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_wd);
    for (int k = 1; k < n; k++) tick;
    chk({tag, ".no_early_ready"}, {bus.i_ready, bus.d_ready}, 2'b00);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mrd;
    tick;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    chk({tag, ".i_ready"}, bus.i_ready, is_i);
    chk({tag, ".d_ready"}, bus.d_ready, !is_i);
    chk({tag, ".resp_err"}, bus.resp_err, 0);
    chk({tag, ".mem_req_off"}, bus.mem_req, 0);
    chk({tag, ".rdata"}, is_i ? bus.i_rdata : bus.d_rdata, exp_rd);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    tick;
    tick;
    chk("rst.busy", bus.busy, 0);
    chk("rst.mem_req", bus.mem_req, 0);
    chk("rst.mem_we", bus.mem_we, 0);
    chk("rst.ready", {bus.i_ready, bus.d_ready, bus.resp_err}, 3'b000);
    chk("rst.i_rdata", bus.i_rdata, 0);
    chk("rst.d_rdata", bus.d_rdata, 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    bus.i_req = 1; bus.i_addr = 32'h100;
    bus.d_req = 1; bus.d_addr = 32'h208;
    xact("tie1_i", 1, 32'h100, 0, 0, 1, {16{8'h11}}, {16{8'h11}});
    tick;
    xact("tie1_d", 0, 32'h200, 0, 0, 1, {16{8'h22}}, {16{8'h22}});
    tick;
    xact("tie2_i", 1, 32'h100, 0, 0, 2, {16{8'h33}}, {16{8'h33}});
    tick;
    xact("tie2_d", 0, 32'h200, 0, 0, 1, {16{8'h44}}, {16{8'h44}});
    bus.i_req = 0; bus.d_req = 0;
    tick;
    chk("idle.busy", bus.busy, 0);
    bus.i_req = 1; bus.d_req = 1;
    xact("tie3_i", 1, 32'h100, 0, 0, 1, {16{8'h55}}, {16{8'h55}});
    bus.i_req = 0;
    tick;
    xact("tie3_d", 0, 32'h200, 0, 0, 1, {16{8'h66}}, {16{8'h66}});
    bus.d_req = 0;
    tick;
    bus.i_req = 1; bus.i_addr = 32'h84;
    xact("lone", 1, 32'h80, 0, 0, 3, {16{8'hAA}}, {16{8'hAA}});
    bus.i_req = 0;
    tick;
    chk("lone.after", {bus.busy, bus.i_ready}, 2'b00);
    bus.mem_ready = 1; bus.mem_rdata = {16{8'h77}};
    tick;
    bus.mem_ready = 0;
    tick;
    chk("spur.busy", bus.busy, 0);
    chk("spur.ready", {bus.i_ready, bus.d_ready}, 2'b00);
    chk("spur.i_rdata", bus.i_rdata, {16{8'hAA}});
    chk("spur.d_rdata", bus.d_rdata, {16{8'h66}});
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = {8{16'h1234}};
    xact("wb", 0, 32'h200, 1, {8{16'h1234}}, 1, {16{8'hFF}}, {16{8'h66}});
    bus.d_req = 0; bus.d_we = 0; bus.d_wdata = '0;
    tick;
    bus.i_req = 1; bus.i_addr = 32'h300;
    cnt = 0;
    do begin
      tick;
      cnt++;
    end while (!bus.i_ready && cnt < 100);
    chk("to.cycles", cnt, 65);
    chk("to.resp_err", bus.resp_err, 1);
    chk("to.i_rdata", bus.i_rdata, 0);
    bus.i_req = 0;
    tick;
    chk("to.idle", {bus.busy, bus.resp_err, bus.i_ready}, 3'b000);
    bus.i_req = 1; bus.i_addr = 32'h340;
    xact("race", 1, 32'h340, 0, 0, 64, {16{8'hBB}}, {16{8'hBB}});
    bus.i_req = 0;
    tick;
    bus.d_req = 1; bus.d_addr = 32'h400;
    tick;
    chk("mid.busy", bus.busy, 1);
    chk("mid.mem_addr", bus.mem_addr, 32'h400);
    tick;
    bus.i_req = 1; bus.i_addr = 32'h500;
    #2 reset = 1'b1;
    #1;
    chk("mid.mem_req", bus.mem_req, 0);
    chk("mid.busy_off", bus.busy, 0);
    chk("mid.mem_addr_clr", bus.mem_addr, 0);
    chk("mid.rdata_clr", {bus.i_rdata, bus.d_rdata}, 0);
    tick;
    reset = 1'b0;
    xact("post_i", 1, 32'h500, 0, 0, 1, {16{8'hCC}}, {16{8'hCC}});
    bus.i_req = 0;
    tick;
    xact("post_d", 0, 32'h400, 0, 0, 1, {16{8'hDD}}, {16{8'hDD}});
    bus.d_req = 0;
    tick;
    chk("end.busy", bus.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width in bits.
REQ-002 Parameter: LINE_W, 128, cache line width in bits (4 words).
REQ-003 Parameter: TIMEOUT, 64, maximum cycles to wait for mem_ready before aborting.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: i_req  in  1  instruction-side line-refill request; level signal.
REQ-007 Port: i_addr  in  ADDR_W  instruction refill address.
REQ-008 Port: i_rdata  out  LINE_W  refill line returned to the instruction side.
REQ-009 Port: i_ready  out  1  one-cycle completion pulse for the instruction side.
REQ-010 Port: d_req  in  1  data-side request; level signal.
REQ-011 Port: d_we  in  1  data-side request type: 1 = line writeback, 0 = refill.
REQ-012 Port: d_addr  in  ADDR_W  data-side address.
REQ-013 Port: d_wdata  in  LINE_W  writeback line.
REQ-014 Port: d_rdata  out  LINE_W  refill line returned to the data side.
REQ-015 Port: d_ready  out  1  one-cycle completion pulse for the data side.
REQ-016 Port: resp_err  out  1  timeout flag, qualified by i_ready or d_ready.
REQ-017 Port: mem_req  out  1  memory request, held high until mem_ready.
REQ-018 Port: mem_we, mem_addr, mem_wdata  out  1/ADDR_W/LINE_W  latched request fields.
REQ-019 Port: mem_rdata  in  LINE_W  memory read line; valid while mem_ready is high.
REQ-020 Port: mem_ready  in  1  memory completion pulse.
REQ-021 Port: busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
REQ-023 IDLE transitions:
- only i_req set -> BUSY_I.
- only d_req set -> BUSY_D.
- both set -> the requester that was not granted last (round-robin).
- neither set -> stay in IDLE.
REQ-024 On grant, addr/we/wdata are latched into internal registers; mem_addr[3:0] SHALL be forced to 0 (line-aligned).
- Instruction grants always use mem_we=0.
REQ-025 In BUSY_x: mem_req=1 with the latched fields, which stay stable.
- mem_ready=1 -> capture mem_rdata into x_rdata (refills only) and go to RESP_x.
REQ-026 In RESP_x: x_ready=1 for exactly one cycle, then return to IDLE; last-owner register updated to x.
REQ-027 Minimum latency: req sampled in IDLE at cycle 0 with mem_ready at cycle 1 gives x_ready at cycle 2.
REQ-028 req is ignored during RESP; the requester SHALL drop req or present a new request in the cycle after ready.
REQ-029 Watchdog counter: cleared on entry to BUSY, increments each BUSY cycle.
- Reaching TIMEOUT-1 without mem_ready -> go to RESP_x with resp_err=1 and x_rdata=0.
REQ-030 mem_ready in IDLE or RESP is ignored; no state change.
REQ-031 mem_ready in the same cycle as the watchdog expiry: mem_ready wins, resp_err=0.
REQ-032 x_rdata holds its value until the next completed refill for x; writeback completion leaves d_rdata unchanged.
REQ-033 A requester's req changes while in BUSY have no effect on the latched fields.

Reset
REQ-034 Asserting reset at any time, including mid-transaction, SHALL immediately:
- put the FSM in IDLE.
- drive mem_req, mem_we, i_ready, d_ready, resp_err and busy to 0.
- clear i_rdata, d_rdata, mem_addr, mem_wdata and the watchdog to 0.
- set the last-owner register to D, so I wins the first tie.
REQ-035 No memory transaction is resumed after reset; requesters reissue.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the FSM state enum, the owner enum (OWN_I, OWN_D), and the LINE_W and OFFSET_BITS=4 constants.
REQ-037 Sub-module rr_arbiter_2 SHALL hold the 2-way round-robin pick logic and the last-owner register; the top holds the FSM, latches and watchdog.

Verification
REQ-038 Lone refill:
- stimulus: i_req, i_addr=0x0000_0084; mem_ready at 3rd BUSY cycle with mem_rdata=0xA..A.
- required: mem_addr=0x0000_0080, mem_we=0; i_ready one cycle with i_rdata=0xA..A.
REQ-039 Simultaneous requests from reset:
- stimulus: i_req and d_req in the same cycle.
- required: I granted first, then D.
- then D and I re-raised together: I granted before D (D was last owner); grants stay strictly alternating while both are held.
REQ-040 Writeback:
- stimulus: d_req, d_we=1, d_addr=0x200, d_wdata=0x1234...; mem_ready after 1 cycle.
- required: mem_we=1 with mem_wdata matching; d_ready pulses; d_rdata unchanged.
REQ-041 Timeout:
- stimulus: i_req with mem_ready never asserted.
- required: after 64 BUSY cycles, i_ready=1, resp_err=1, i_rdata=0, then IDLE.
REQ-042 Reset mid-BUSY_D:
- required: mem_req drops asynchronously and busy=0.
- after reset release, a pending i_req is granted first.
REQ-043 Spurious mem_ready in IDLE: no ready pulse, no state change.
